// File: rtl/adc_scan_collector.sv
// ADC scan sequencer with first-word-fall-through result FIFO.
// Define ADC_CHANNEL_TAG_EN to tag each stored sample with its channel in out_data[15:12].
module adc_scan_collector #(
  parameter int FIFO_AW = 4
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               enable,
  input  logic [3:0]         ch_first,
  input  logic [3:0]         ch_last,
  input  logic [15:0]        period,
  input  logic               clear,
  output logic               adc_start,
  output logic [3:0]         adc_channel,
  input  logic               adc_ready,
  input  logic [11:0]        adc_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [15:0]        out_data,
  output logic [FIFO_AW:0]   level,
  output logic               overrun
);

`ifdef ADC_CHANNEL_TAG_EN
  localparam int DW = 16;
`else
  localparam int DW = 12;
`endif
  localparam int DEPTH = 2 ** FIFO_AW;
  localparam logic [FIFO_AW-1:0] PTR_ONE = 1;
  localparam logic [FIFO_AW:0]   LVL_ONE = 1;

  typedef enum logic [1:0] {IDLE, WAIT, CONV, STORE} state_t;

  state_t              state, state_nx;
  logic                armed;
  logic [15:0]         cnt;
  logic [15:0]         period_eff;
  logic                load_cnt;
  logic [11:0]         sample;
  logic [DW-1:0]       mem [DEPTH];
  logic [DW-1:0]       wr_word;
  logic [DW-1:0]       head;
  logic [FIFO_AW-1:0]  wr_ptr, rd_ptr;
  logic                full, push, pop;

  assign period_eff = (period < 16'd4) ? 16'd4 : period;
  assign adc_start  = (state == CONV);

  always_comb begin
    state_nx = state;
    load_cnt = 1'b0;
    unique case (state)
      IDLE: begin
        // armed delays the first start to the second edge after reset release
        if (enable && armed) begin
          state_nx = CONV;
          load_cnt = 1'b1;
        end
      end
      CONV:  if (adc_ready) state_nx = STORE;
      STORE: state_nx = WAIT;
      WAIT: begin
        if (!enable) begin
          state_nx = IDLE;
        end else if (cnt == '0) begin
          state_nx = CONV;
          load_cnt = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      armed       <= 1'b0;
      cnt         <= '0;
      adc_channel <= '0;
      sample      <= '0;
    end else begin
      state <= state_nx;
      armed <= 1'b1;
      if (load_cnt)
        cnt <= period_eff - 16'd1;
      else if (cnt != '0)
        cnt <= cnt - 16'd1;
      if (state == IDLE && state_nx == CONV)
        adc_channel <= ch_first;
      else if (state == STORE)
        adc_channel <= (adc_channel >= ch_last || ch_first > ch_last) ? ch_first
                                                                       : adc_channel + 4'd1;
      if (state == CONV && adc_ready)
        sample <= adc_data;
    end
  end

  // When full, a same-cycle pop frees the slot the write lands in (wr_ptr == rd_ptr).
  assign full      = level[FIFO_AW];
  assign out_valid = (level != '0);
  assign pop       = out_valid && out_ready && !clear;
  assign push      = (state == STORE) && !clear && (!full || pop);

`ifdef ADC_CHANNEL_TAG_EN
  assign wr_word  = {adc_channel, sample};
  assign head     = mem[rd_ptr];
  assign out_data = out_valid ? head : '0;
`else
  assign wr_word  = sample;
  assign head     = mem[rd_ptr];
  assign out_data = out_valid ? {4'h0, head} : '0;
`endif

  always_ff @(posedge clock) begin
    if (push)
      mem[wr_ptr] <= wr_word;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
      overrun <= 1'b0;
    end else if (clear) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
      overrun <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      if (push && !pop)
        level <= level + LVL_ONE;
      else if (pop && !push)
        level <= level - LVL_ONE;
      if (state == STORE && full && !pop)
        overrun <= 1'b1;
    end
  end

endmodule

// File: doc/adc_scan_collector.md
ADC_SCAN_COLLECTOR -- requirements
Module: adc_scan_collector

Interface
REQ-001 SHALL have parameter FIFO_AW, default 4, FIFO address width (depth 2**FIFO_AW words).
REQ-002 SHALL have port clock  input  1  single system clock (40 MHz ADC clock domain); all logic rising-edge.
REQ-003 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port enable  input  1  level; 1 = scanning runs.
REQ-005 SHALL have ports ch_first, ch_last  input  4 each  inclusive scan range.
REQ-006 SHALL have port period  input  16  clock cycles from one adc_start rise to the next.
REQ-007 SHALL have port clear  input  1  one-cycle pulse; flushes FIFO, clears overrun.
REQ-008 SHALL have ports adc_start  output  1, adc_channel  output  4  to converter start/channel.
REQ-009 SHALL have ports adc_ready  input  1, adc_data  input  12  from converter; adc_ready is a one-cycle result strobe.
REQ-010 SHALL have ports out_valid  output  1, out_ready  input  1, out_data  output  16  downstream stream (F2H/UART).
REQ-011 SHALL have ports level  output  FIFO_AW+1  FIFO occupancy, overrun  output  1  sticky sample-drop flag.

Function
REQ-012 SHALL implement states IDLE, WAIT, CONV, STORE.
REQ-013 IDLE: adc_start=0; enable=1 -> CONV with adc_channel=ch_first, period counter loaded.
REQ-014 CONV: adc_start=1, adc_channel stable; stays until adc_ready=1, adc_data captured that cycle -> STORE.
REQ-015 STORE (one cycle): adc_start=0; captured word written to FIFO if not full; channel advances -> WAIT.
REQ-016 Channel advance: ch+1; if ch>=ch_last then ch_first (wrap); ch_first>ch_last scans ch_first only.
REQ-017 Period counter: free-running down-count from period-1 reloaded on each CONV entry; WAIT -> CONV when it reaches 0; period<4 treated as 4.
REQ-018 WAIT with enable=0 -> IDLE; enable=0 during CONV SHALL complete the conversion (no abort).
REQ-019 FIFO full at STORE: word dropped, overrun set to 1; FIFO contents unchanged.
REQ-020 out_valid=1 iff FIFO non-empty; out_data = head word (first-word-fall-through); pop when out_valid&&out_ready.
REQ-021 Simultaneous write and pop SHALL be allowed when full or empty-with-valid; level unchanged; no drop when full and popping same cycle.
REQ-022 clear SHALL empty FIFO (level=0, out_valid=0) and clear overrun next cycle; clear coincident with write discards that write; FSM unaffected.
REQ-023 level SHALL equal writes minus pops, range 0..2**FIFO_AW.
REQ-024 Latency: adc_ready cycle N -> out_valid=1 at N+2 when FIFO was empty.

Reset
REQ-025 reset_n=0 SHALL asynchronously force: state IDLE, adc_start=0, adc_channel=0, out_valid=0, out_data=0, level=0, overrun=0, period counter 0.
REQ-026 Reset mid-CONV SHALL abandon the conversion; an adc_ready arriving after release while in IDLE SHALL be ignored.
REQ-027 First adc_start SHALL rise no earlier than the second clock edge after reset_n release with enable=1.

Configuration
REQ-028 Macro ADC_CHANNEL_TAG_EN defined: out_data[15:12]=channel of sample, [11:0]=adc_data.
REQ-029 Macro ADC_CHANNEL_TAG_EN undefined: out_data[15:12]=0, [11:0]=adc_data; FIFO may store 12 bits only.

Verification
REQ-030 enable=1, ch 0..0, period=100, converter returns 0x801 -> adc_start rises every 100 cycles; out_data=0x0801 (tag on: 0x0801).
REQ-031 ch_first=2, ch_last=4, data 0x911 -> adc_channel sequence 2,3,4,2; tagged out_data 0x2911,0x3911,0x4911,0x2911.
REQ-032 out_ready=0, FIFO_AW=4, 17 conversions -> level=16, overrun=1, 17th sample dropped; clear -> level=0, overrun=0.
REQ-033 FIFO full and out_ready=1 in STORE cycle -> no drop, level stays 16, overrun stays 0.
REQ-034 reset_n pulsed low mid-CONV -> adc_start=0 immediately, level=0; late adc_ready ignored; scan restarts at ch_first.
REQ-035 enable dropped during CONV -> conversion completes, sample stored, then IDLE with adc_start=0.
